pattern_writer: RTL and testbench
=================================

# pattern_writer

Parametrised test-pattern source for the SRAM frame-buffer write path. While the arbiter holds `write` high, the block drives one pixel word per clock onto the shared memory data bus and walks a COLS × ROWS raster. It offers four selectable patterns: colour bars, checkerboard, gradient and solid. An `over` override forces a fixed colour, and a one-cycle pulse marks frame completion. When `write` is low the bus is released (high-Z) so reads are not disturbed.

## Interface
- `DATA_W`, 6: pixel word width.
- `COLS`, 100: words per line; ≥ HBANDS.
- `ROWS`, 600: lines per frame; ≥ VBANDS.
- `HBANDS`, 4: horizontal colour bands (across a line).
- `VBANDS`, 16: vertical colour bands (down the frame).
- `OVER_COLOUR`, 6'b000011: word forced while `over` = 1.
- `LINE_RESTART`, 0: 1 returns the column to 0 whenever `write` drops (legacy behaviour); 0 holds position.

Ports:
- `clk`  in  1  system clock (50 MHz); single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `write`  in  1  write window; one pixel is consumed per clock while high.
- `frame_start`  in  1  synchronous restart to the raster origin.
- `mode`  in  2  pattern: 0 bars, 1 checkerboard, 2 gradient, 3 solid.
- `solid_colour`  in  DATA_W  colour used by mode 3.
- `over`  in  1  override; forces OVER_COLOUR.
- `mem_data`  out  DATA_W  pixel word when `write` = 1, else all Z.
- `col_idx`  out  clog2(COLS)  current column.
- `row_idx`  out  clog2(ROWS)  current line.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame.

## Operation
- **Position counters.** `col_idx` and `row_idx` start at 0.
  - Each rising edge with `write` = 1 increments `col_idx`.
  - At COLS−1, `col_idx` wraps to 0 and `row_idx` increments.
  - At ROWS−1 with `col_idx` = COLS−1, both wrap to 0 and `frame_done` is set.
- **Band counters.**
  - Horizontal band width is BW = COLS/HBANDS (floor). A sub-counter advances `hband` every BW columns.
  - `hband` saturates at HBANDS−1, so the last band absorbs the remainder. `hband` clears on column wrap.
  - `vband` works the same way with BH = ROWS/VBANDS, advancing on line wrap and clearing on frame wrap.
  - No dividers appear in the datapath; only the constant BW/BH are computed at elaboration.
- **Mode latch.** `mode` is captured into `mode_q` on every edge where the position is the origin (0,0) and a pixel is consumed, and also on `frame_start`. The pattern therefore never changes mid-frame.
- **Pixel word** (combinational from counters, `mode_q`, `over`):
  - `over` = 1: OVER_COLOUR, regardless of mode.
  - bars: (hband·VBANDS + vband) mod 2^DATA_W.
  - checkerboard: all-ones if (hband xor vband) bit 0 = 1, else all-zeros.
  - gradient: `col_idx` mod 2^DATA_W.
  - solid: `solid_colour`. It is sampled live, not latched.
- **Bus drive.** `mem_data` = word when `write` = 1, else Z.
- **Write low.**
  - LINE_RESTART = 0: all counters hold.
  - LINE_RESTART = 1: `col_idx`, `hband` and its sub-counter clear to 0; `row_idx` and `vband` hold.
- **`frame_start`.** Clears all counters to the origin and latches `mode`. It has priority over `write` advance in the same cycle; no pixel is consumed that cycle, although the bus is still driven with the origin word.
- **Reset.** Asserting `rst` at any time, including mid-frame, asynchronously clears the counters, `mode_q` and `frame_done` to 0.

## Timing
- **Reset values:** `col_idx` 0, `row_idx` 0, `frame_done` 0, `mode_q` 0 (bars). `mem_data` is Z if `write` = 0.
- **Zero latency:** the word for position (col,row) is valid in the same cycle that position is displayed. It is consumed at the rising edge where `write` = 1.
- **`frame_done`:** high exactly one cycle, in the cycle after the edge that consumed pixel (COLS−1, ROWS−1).
- **`over` and `write`:** both take effect combinationally in the current cycle.
- **Wrap without gap:** a frame wrap and the next frame's first pixel proceed without a gap. Pixel (0,0) of the new frame is valid in the same cycle `frame_done` is high, and uses the new `mode` once it is consumed.
- **`frame_start` with `frame_done`:** `frame_start` in the frame_done cycle is legal; `frame_done` still completes its single pulse.

## Test plan
Bench parameters for all scenarios: COLS=8, ROWS=4, HBANDS=2, VBANDS=2.
- **Reset and bars raster.** Reset, then hold `write` high with mode 0 for 32 clocks.
  - Words are 0 for columns 0–3 and 2 for columns 4–7 on rows 0–1.
  - Words are 1 and 3 on rows 2–3.
  - `frame_done` pulses once, in cycle 33.
- **Override.** Checkerboard with `over` pulsed mid-line → OVER_COLOUR during the pulse only, and counters advance normally. `write` = 0 → `mem_data` is all Z.
- **Write gaps, LINE_RESTART = 0.** Toggle `write` 1/0 each clock → 32 consumed pixels complete the frame, and counters hold in the gaps.
- **Write drop, LINE_RESTART = 1.** Drop `write` at column 5 → the next word shown is column 0 of the same row.
- **Mode change mid-frame.** Switch mode 0→2 at row 1 → bars continue to the end of the frame. The next frame shows gradient 0..7 per line.
- **Restart and async reset.** Assert `frame_start` together with `write` at (6,2) → the next cycle is at (0,0) and no `frame_done` pulses. Assert `rst` asynchronously mid-cycle → `col_idx`, `row_idx` and `frame_done` go to 0 immediately.

Source files
------------

// File: rtl/pattern_writer.sv
// pattern_writer: raster test-pattern source for the SRAM frame-buffer write path.
// Walks a COLS x ROWS raster one word per consumed clock and drives colour bars,
// checkerboard, gradient or a solid colour onto a shared bus that is released
// (high-Z) whenever the write window is closed.
module pattern_writer #(
   parameter int                DATA_W       = 6,
   parameter int                COLS         = 100,
   parameter int                ROWS         = 600,
   parameter int                HBANDS       = 4,
   parameter int                VBANDS       = 16,
   parameter logic [DATA_W-1:0] OVER_COLOUR  = 6'b000011,
   parameter bit                LINE_RESTART = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       write,
   input  logic                       frame_start,
   input  logic [1:0]                 mode,
   input  logic [DATA_W-1:0]          solid_colour,
   input  logic                       over,
   output wire  [DATA_W-1:0]          mem_data,
   output logic [$clog2(COLS)-1:0]    col_idx,
   output logic [$clog2(ROWS)-1:0]    row_idx,
   output logic                       frame_done
);

   localparam int CW  = $clog2(COLS);
   localparam int RW  = $clog2(ROWS);
   // Band sizes are elaboration-time constants; the datapath never divides.
   localparam int BW  = COLS / HBANDS;
   localparam int BH  = ROWS / VBANDS;
   localparam int HSW = (BW > 1) ? $clog2(BW) : 1;
   localparam int VSW = (BH > 1) ? $clog2(BH) : 1;
   localparam int HBW = (HBANDS > 1) ? $clog2(HBANDS) : 1;
   localparam int VBW = (VBANDS > 1) ? $clog2(VBANDS) : 1;

   localparam logic [CW-1:0]  COL_LAST   = CW'(COLS - 1);
   localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
   localparam logic [HSW-1:0] HSUB_LAST  = HSW'(BW - 1);
   localparam logic [VSW-1:0] VSUB_LAST  = VSW'(BH - 1);
   localparam logic [HBW-1:0] HBAND_LAST = HBW'(HBANDS - 1);
   localparam logic [VBW-1:0] VBAND_LAST = VBW'(VBANDS - 1);
   localparam logic [CW-1:0]  COL_STEP   = CW'(1);
   localparam logic [RW-1:0]  ROW_STEP   = RW'(1);
   localparam logic [HSW-1:0] HSUB_STEP  = HSW'(1);
   localparam logic [VSW-1:0] VSUB_STEP  = VSW'(1);
   localparam logic [HBW-1:0] HBAND_STEP = HBW'(1);
   localparam logic [VBW-1:0] VBAND_STEP = VBW'(1);

   logic [CW-1:0]     col_r;
   logic [RW-1:0]     row_r;
   logic [HSW-1:0]    hsub_r;
   logic [VSW-1:0]    vsub_r;
   logic [HBW-1:0]    hband_r;
   logic [VBW-1:0]    vband_r;
   logic [1:0]        mode_q_r;
   logic              frame_done_r;

   logic              consume_s;
   logic              col_wrap_s;
   logic              row_last_s;
   logic              at_origin_s;
   logic [DATA_W-1:0] word_s;

   // Bar colour index: band position flattened as hband*VBANDS + vband, truncated to the word.
   function automatic logic [DATA_W-1:0] bar_colour(input logic [HBW-1:0] hb,
                                                    input logic [VBW-1:0] vb);
      logic [31:0] idx;
      idx = 32'(hb) * 32'(VBANDS) + 32'(vb);
      return idx[DATA_W-1:0];
   endfunction

   // frame_start wins over write, so a restart cycle never consumes a pixel.
   assign consume_s   = write & ~frame_start;
   assign col_wrap_s  = (col_r == COL_LAST);
   assign row_last_s  = (row_r == ROW_LAST);
   assign at_origin_s = (col_r == {CW{1'b0}}) & (row_r == {RW{1'b0}});

   // Raster position and band counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_r   <= {CW{1'b0}};
         row_r   <= {RW{1'b0}};
         hsub_r  <= {HSW{1'b0}};
         vsub_r  <= {VSW{1'b0}};
         hband_r <= {HBW{1'b0}};
         vband_r <= {VBW{1'b0}};
      end else if (frame_start) begin
         col_r   <= {CW{1'b0}};
         row_r   <= {RW{1'b0}};
         hsub_r  <= {HSW{1'b0}};
         vsub_r  <= {VSW{1'b0}};
         hband_r <= {HBW{1'b0}};
         vband_r <= {VBW{1'b0}};
      end else if (write) begin
         if (col_wrap_s) begin
            col_r   <= {CW{1'b0}};
            hsub_r  <= {HSW{1'b0}};
            hband_r <= {HBW{1'b0}};
            if (row_last_s) begin
               row_r   <= {RW{1'b0}};
               vsub_r  <= {VSW{1'b0}};
               vband_r <= {VBW{1'b0}};
            end else begin
               row_r <= row_r + ROW_STEP;
               // The last vertical band saturates and absorbs the remainder rows.
               if (vsub_r == VSUB_LAST) begin
                  vsub_r <= {VSW{1'b0}};
                  if (vband_r != VBAND_LAST) begin
                     vband_r <= vband_r + VBAND_STEP;
                  end else begin
                     vband_r <= vband_r;
                  end
               end else begin
                  vsub_r <= vsub_r + VSUB_STEP;
               end
            end
         end else begin
            col_r <= col_r + COL_STEP;
            // The last horizontal band saturates and absorbs the remainder columns.
            if (hsub_r == HSUB_LAST) begin
               hsub_r <= {HSW{1'b0}};
               if (hband_r != HBAND_LAST) begin
                  hband_r <= hband_r + HBAND_STEP;
               end else begin
                  hband_r <= hband_r;
               end
            end else begin
               hsub_r <= hsub_r + HSUB_STEP;
            end
         end
      end else if (LINE_RESTART) begin
         // Legacy mode: a closed window rewinds to the start of the current line.
         col_r   <= {CW{1'b0}};
         hsub_r  <= {HSW{1'b0}};
         hband_r <= {HBW{1'b0}};
      end else begin
         col_r <= col_r;
      end
   end

   // Pattern select is only sampled at the frame origin so a frame never mixes patterns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q_r <= 2'd0;
      end else if (frame_start || (consume_s && at_origin_s)) begin
         mode_q_r <= mode;
      end else begin
         mode_q_r <= mode_q_r;
      end
   end

   // One-cycle pulse following consumption of the last pixel of the frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= consume_s & col_wrap_s & row_last_s;
      end
   end

   // Pixel word for the current position; override has absolute priority.
   always_comb begin
      word_s = {DATA_W{1'b0}};
      if (over) begin
         word_s = OVER_COLOUR;
      end else begin
         case (mode_q_r)
            2'd0:    word_s = bar_colour(hband_r, vband_r);
            2'd1:    word_s = (hband_r[0] ^ vband_r[0]) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            2'd2:    word_s = DATA_W'(32'(col_r));
            2'd3:    word_s = solid_colour;
            default: word_s = {DATA_W{1'b0}};
         endcase
      end
   end

   assign mem_data   = write ? word_s : {DATA_W{1'bz}};
   assign col_idx    = col_r;
   assign row_idx    = row_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_pattern_writer.sv
// tb_pattern_writer: directed plus random stimulus for pattern_writer, with both
// LINE_RESTART settings instantiated side by side and checked against a
// position-level reference model.
module tb_pattern_writer;

   localparam int DW   = 6;
   localparam int COLS = 8;
   localparam int ROWS = 4;
   localparam int HB   = 2;
   localparam int VB   = 2;
   localparam logic [DW-1:0] OC = 6'b000011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          write;
   logic          frame_start;
   logic          over;
   logic [1:0]    mode;
   logic [DW-1:0] solid;

   // Pulled-up buses: a released bus reads all ones.
   tri1 [DW-1:0]  bus0;
   tri1 [DW-1:0]  bus1;
   logic [2:0]    col0, col1;
   logic [1:0]    row0, row1;
   logic          fd0, fd1;

   pattern_writer #(.DATA_W(DW), .COLS(COLS), .ROWS(ROWS), .HBANDS(HB), .VBANDS(VB),
                    .OVER_COLOUR(OC), .LINE_RESTART(1'b0)) dut0 (
      .clk(clk), .rst(rst), .write(write), .frame_start(frame_start), .mode(mode),
      .solid_colour(solid), .over(over), .mem_data(bus0), .col_idx(col0),
      .row_idx(row0), .frame_done(fd0));

   pattern_writer #(.DATA_W(DW), .COLS(COLS), .ROWS(ROWS), .HBANDS(HB), .VBANDS(VB),
                    .OVER_COLOUR(OC), .LINE_RESTART(1'b1)) dut1 (
      .clk(clk), .rst(rst), .write(write), .frame_start(frame_start), .mode(mode),
      .solid_colour(solid), .over(over), .mem_data(bus1), .col_idx(col1),
      .row_idx(row1), .frame_done(fd1));

   int checks   = 0;
   int failures = 0;

   // Reference model state, index 0 = hold-position instance, 1 = line-restart instance.
   int m_col [2];
   int m_row [2];
   int m_mq  [2];
   int m_fd  [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input int i);
      int hb, vb;
      hb = m_col[i] / (COLS / HB);
      if (hb > HB - 1) hb = HB - 1;
      vb = m_row[i] / (ROWS / VB);
      if (vb > VB - 1) vb = VB - 1;
      if (!write) return 32'h3F;
      if (over) return 32'(OC);
      case (m_mq[i])
         0:       return 32'((hb * VB + vb) % 64);
         1:       return (((hb ^ vb) & 1) == 1) ? 32'h3F : 32'h0;
         2:       return 32'(m_col[i] % 64);
         default: return 32'(solid);
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_col[i] = 0; m_row[i] = 0; m_mq[i] = 0; m_fd[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (frame_start) begin
            m_col[i] = 0; m_row[i] = 0; m_mq[i] = int'(mode); m_fd[i] = 0;
         end else if (write) begin
            if (m_col[i] == 0 && m_row[i] == 0) m_mq[i] = int'(mode);
            m_fd[i] = (m_col[i] == COLS - 1 && m_row[i] == ROWS - 1) ? 1 : 0;
            if (m_col[i] == COLS - 1) begin
               m_col[i] = 0;
               m_row[i] = (m_row[i] == ROWS - 1) ? 0 : m_row[i] + 1;
            end else begin
               m_col[i] = m_col[i] + 1;
            end
         end else begin
            m_fd[i] = 0;
            if (i == 1) m_col[i] = 0;
         end
      end
   endtask

   task automatic check_all();
      check("col0", 32'(col0), 32'(m_col[0]));
      check("row0", 32'(row0), 32'(m_row[0]));
      check("fd0",  32'(fd0),  32'(m_fd[0]));
      check("bus0", 32'(bus0), exp_word(0));
      check("col1", 32'(col1), 32'(m_col[1]));
      check("row1", 32'(row1), 32'(m_row[1]));
      check("fd1",  32'(fd1),  32'(m_fd[1]));
      check("bus1", 32'(bus1), exp_word(1));
   endtask

   // Check the current cycle, then advance one clock and update the model.
   task automatic cycle();
      #1;
      check_all();
      @(posedge clk);
      model_step();
      #1;
   endtask

   int fd_first;
   int fd_count;

   initial begin
      rst = 1'b1; write = 1'b0; frame_start = 1'b0; over = 1'b0; mode = 2'd0; solid = '0;
      model_reset();
      #12;
      check_all();
      check("reset_col0", 32'(col0), 32'h0);
      check("reset_fd0", 32'(fd0), 32'h0);
      check("reset_bus_released", 32'(bus0), 32'h3F);
      @(posedge clk); #1;
      rst = 1'b0;

      // Bars raster over a full frame plus the first pixel of the next.
      mode = 2'd0; write = 1'b1;
      fd_first = -1; fd_count = 0;
      for (int k = 1; k <= 33; k++) begin
         cycle();
         if (fd0 === 1'b1) begin
            fd_count++;
            if (fd_first < 0) fd_first = k + 1;
         end
      end
      check("bars_fd_cycle", 32'(fd_first), 32'd33);
      check("bars_fd_pulses", 32'(fd_count), 32'd1);

      // Checkerboard with a mid-line override pulse, then a closed window.
      mode = 2'd1; frame_start = 1'b1; write = 1'b1;
      cycle();
      frame_start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         over = (k == 3 || k == 4);
         cycle();
      end
      over = 1'b0; write = 1'b0;
      cycle();
      cycle();

      // Write window toggled every clock: 32 consumed pixels finish the frame.
      mode = 2'd0; frame_start = 1'b1; write = 1'b1;
      cycle();
      frame_start = 1'b0;
      fd_count = 0;
      for (int k = 0; k < 64; k++) begin
         write = (k % 2 == 0);
         cycle();
         if (fd0 === 1'b1) fd_count++;
      end
      check("gaps_fd_pulses", 32'(fd_count), 32'd1);

      // Window dropped at column 5 in gradient mode.
      mode = 2'd2; frame_start = 1'b1; write = 1'b1;
      cycle();
      frame_start = 1'b0;
      for (int k = 0; k < 5; k++) cycle();
      write = 1'b0;
      cycle();
      write = 1'b1;
      #1;
      check("drop_lr1_col", 32'(col1), 32'd0);
      check("drop_lr1_word", 32'(bus1), 32'd0);
      check("drop_lr0_word", 32'(bus0), 32'd5);
      cycle();
      cycle();

      // Mode switched to gradient at row 1: bars finish the frame, gradient follows.
      mode = 2'd0; frame_start = 1'b1; write = 1'b1;
      cycle();
      frame_start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (k == 8) mode = 2'd2;
         cycle();
      end

      // Restart at (6,2) together with write.
      frame_start = 1'b1;
      cycle();
      frame_start = 1'b0;
      for (int k = 0; k < 22; k++) cycle();
      check("restart_at_col", 32'(col0), 32'd6);
      frame_start = 1'b1;
      cycle();
      frame_start = 1'b0; write = 1'b0;
      #1;
      check("restart_col", 32'(col0), 32'd0);
      check("restart_row", 32'(row0), 32'd0);
      check("restart_fd", 32'(fd0), 32'd0);
      cycle();

      // Async reset in the frame_done cycle.
      write = 1'b1;
      for (int k = 0; k < 32; k++) cycle();
      check("prereset_fd", 32'(fd0), 32'd1);
      #2; rst = 1'b1; #1;
      check("async_fd", 32'(fd0), 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;

      // Async reset mid-frame.
      for (int k = 0; k < 11; k++) cycle();
      #2; rst = 1'b1; #1;
      check("async_col", 32'(col0), 32'd0);
      check("async_row", 32'(row0), 32'd0);
      model_reset();
      check_all();
      @(posedge clk); #1;
      rst = 1'b0;

      // Randomised traffic.
      for (int k = 0; k < 400; k++) begin
         write       = ($urandom % 4) != 0;
         over        = ($urandom % 8) == 0;
         mode        = 2'($urandom);
         solid       = DW'($urandom);
         frame_start = ($urandom % 64) == 0;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
